mem_mar_mdr_unit: RTL and testbench
===================================

// Module: mem_mar_mdr_unit
// PURPOSE
//  LC-3 memory interface stage: holds MAR and MDR, loaded from the shared 16-bit CPU bus.
//  Sequences single-word SRAM read/write cycles with a fixed wait-state count and a Ready handshake.
//  Sits directly upstream of the bus gate mux: its MAR and MDR outputs are the MAR/MDR bus sources.
//  Driven by the control FSM through LD_MAR, LD_MDR, MIO_EN, Mem_Req and Mem_WE.
// PARAMETERS
//  WAIT_CYCLES  2   strobe-active cycles per access; legal range 1..15
//  ADDR_W       20  SRAM address width; MAR is zero-extended to ADDR_W
// PORTS
//  Clk             in   1       system clock; all flops are rising-edge
//  Reset           in   1       asynchronous, active-low reset
//  Bus_In          in   16      shared CPU bus value
//  LD_MAR          in   1       load MAR from Bus_In
//  LD_MDR          in   1       load MDR from Bus_In; acts only when MIO_EN=0
//  MIO_EN          in   1       1: MDR source is memory (Mem_Req path); 0: MDR source is bus
//  Mem_Req         in   1       start an access; sampled only in IDLE
//  Mem_WE          in   1       access type, sampled with Mem_Req: 1 = write, 0 = read
//  MAR             out  16      MAR register
//  MDR             out  16      MDR register
//  Mem_Busy        out  1       high in SETUP, STROBE and DONE
//  Mem_Ready       out  1       one-cycle pulse in DONE
//  ADDR            out  ADDR_W  {zeros, MAR}
//  Data_to_SRAM    out  16      equals MDR at all times
//  Data_from_SRAM  in   16      SRAM read data
//  CE_N, OE_N, WE_N  out  1     SRAM strobes, active-low
// BEHAVIOUR
//  Reset (async, Reset=0):
//   - Registers: MAR=0, MDR=0, state=IDLE, wait counter=0.
//   - Outputs: CE_N/OE_N/WE_N=1, Mem_Busy=0, Mem_Ready=0.
//   - Strobes deassert immediately, even mid-access; the in-flight access is abandoned.
//  FSM states: IDLE -> SETUP -> STROBE (WAIT_CYCLES cycles) -> DONE -> IDLE.
//   - IDLE: Mem_Req=1 -> SETUP; latch Mem_WE into a direction flop. Otherwise stay in IDLE.
//   - SETUP: one cycle. CE_N=0. Read: OE_N=0. Write: WE_N=1 (address/data setup).
//   - STROBE: counter counts 0..WAIT_CYCLES-1, then go to DONE.
//     Read: CE_N=0, OE_N=0. Write: CE_N=0, WE_N=0.
//   - DONE: one cycle. CE_N=OE_N=WE_N=1, Mem_Ready=1. Unconditional return to IDLE.
//  Read data: MDR <= Data_from_SRAM on the edge that leaves the last STROBE cycle.
//   - This happens regardless of LD_MDR.
//   - MDR therefore holds the read data in the DONE cycle.
//  Latency (Mem_Req sampled at edge 0):
//   - SETUP in cycle 1; STROBE in cycles 2..WAIT_CYCLES+1; DONE in cycle WAIT_CYCLES+2.
//   - Mem_Req may be asserted again in the IDLE cycle following DONE.
//  Strobes decode from the state and direction registers only, with no combinational input
//   path. CE_N, OE_N and WE_N change only at clock edges.
//  Bus loads in IDLE:
//   - LD_MAR: MAR <= Bus_In.
//   - LD_MDR with MIO_EN=0: MDR <= Bus_In.
//   - LD_MDR with MIO_EN=1: no effect.
//  Loads outside IDLE: while Mem_Busy=1, LD_MAR and LD_MDR are ignored.
//   MAR and MDR stay stable for the whole access.
//  Mem_Req while busy: ignored, not queued.
//  Same edge, LD_MAR (or LD_MDR) with Mem_Req in IDLE:
//   - The register loads and the access starts on that edge.
//   - The access uses the newly loaded value, since ADDR and Data_to_SRAM come from the registers.
//  Mem_WE is ignored except at the Mem_Req sample.
//  Widths: ADDR = {(ADDR_W-16)'b0, MAR}; the wait counter is 4 bits.
// STRUCTURE
//  Package lc3_mem_pkg:
//   - typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} mem_state_t
//   - localparam WORD_W = 16
//  Sub-module reg_16: load-enable 16-bit register with async active-low reset.
//   - Instantiated twice, for MAR and MDR.
//   - The MDR data/load select is muxed in the parent.
//  Wait counter, direction flop and FSM live in the parent.
// TESTING
//  1. Reset=0 mid-STROBE of a read -> same cycle: CE_N=OE_N=1, Busy=0. After release: MAR=0, MDR=0, IDLE.
//  2. Bus_In=16'h3000, LD_MAR; then Mem_Req, Mem_WE=0, SRAM returns 16'hBEEF; WAIT_CYCLES=2:
//     -> ADDR=20'h03000; OE_N=0 for cycles 1-3; MDR=16'hBEEF and Mem_Ready=1 in cycle 4.
//  3. LD_MDR, MIO_EN=0, Bus_In=16'h1234, same edge as Mem_Req, Mem_WE=1:
//     -> WE_N=0 only in STROBE cycles; Data_to_SRAM=16'h1234 throughout.
//  4. LD_MAR with Bus_In=16'hFFFF and a second Mem_Req during STROBE -> MAR unchanged, no second access.
//     Mem_Ready pulses exactly once.
//  5. LD_MDR with MIO_EN=1 in IDLE, Bus_In=16'h5555 -> MDR unchanged.
//  6. WAIT_CYCLES=1 and =15: count strobe-low cycles, expect 1 and 15. Back-to-back reads are 4 cycles apart at WAIT_CYCLES=1.

Source files
------------

// File: rtl/mem_mar_mdr_unit_pkg.sv
// Shared types and constants for the LC-3 MAR/MDR memory interface stage.
package lc3_mem_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} mem_state_t;

endpackage

// File: rtl/mem_mar_mdr_unit_if.sv
// Control-side and SRAM-side signals of the memory interface stage.
interface mem_mar_mdr_unit_if #(
    parameter int unsigned AddrW = 20
) ();
    import lc3_mem_pkg::*;

    logic [WORD_W-1:0] bus_in;
    logic              ld_mar;
    logic              ld_mdr;
    logic              mio_en;
    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mar;
    logic [WORD_W-1:0] mdr;
    logic              mem_busy;
    logic              mem_ready;
    logic [AddrW-1:0]  addr;
    logic [WORD_W-1:0] data_to_sram;
    logic [WORD_W-1:0] data_from_sram;
    logic              ce_n;
    logic              oe_n;
    logic              we_n;

    modport master (
        output bus_in, ld_mar, ld_mdr, mio_en, mem_req, mem_we, data_from_sram,
        input  mar, mdr, mem_busy, mem_ready, addr, data_to_sram, ce_n, oe_n, we_n
    );

    modport slave (
        input  bus_in, ld_mar, ld_mdr, mio_en, mem_req, mem_we, data_from_sram,
        output mar, mdr, mem_busy, mem_ready, addr, data_to_sram, ce_n, oe_n, we_n
    );

endinterface

// File: rtl/mem_mar_mdr_unit_reg_16.sv
// Load-enable word register with asynchronous active-low reset.
module reg_16
    import lc3_mem_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ld_i,
    input  logic [WORD_W-1:0] d_i,
    output logic [WORD_W-1:0] q_o
);

    logic [WORD_W-1:0] q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (ld_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mem_mar_mdr_unit.sv
// LC-3 memory stage: MAR/MDR registers plus a fixed wait-state SRAM access sequencer.
module mem_mar_mdr_unit
    import lc3_mem_pkg::*;
#(
    parameter int unsigned WaitCycles = 2,
    parameter int unsigned AddrW      = 20
) (
    input logic               clk_i,
    input logic               rst_ni,
    mem_mar_mdr_unit_if.slave mem_if
);

    localparam logic [3:0] LastCnt = 4'(WaitCycles - 1);

    mem_state_t        state_q, state_d;
    logic              dir_q, dir_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              idle, last_strobe, capture, mar_ld, mdr_ld;
    logic [WORD_W-1:0] mdr_in, mar, mdr;

    assign idle        = (state_q == IDLE);
    assign last_strobe = (state_q == STROBE) && (cnt_q == LastCnt);
    // Read data is captured on the edge that leaves the last strobe cycle.
    assign capture     = last_strobe && !dir_q;
    assign mar_ld      = idle && mem_if.ld_mar;
    assign mdr_ld      = (idle && mem_if.ld_mdr && !mem_if.mio_en) || capture;
    assign mdr_in      = capture ? mem_if.data_from_sram : mem_if.bus_in;

    reg_16 u_mar (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ld_i   (mar_ld),
        .d_i    (mem_if.bus_in),
        .q_o    (mar)
    );

    reg_16 u_mdr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ld_i   (mdr_ld),
        .d_i    (mdr_in),
        .q_o    (mdr)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = 4'd0;
        unique case (state_q)
            IDLE: begin
                if (mem_if.mem_req) begin
                    state_d = SETUP;
                    dir_d   = mem_if.mem_we;
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: begin
                if (last_strobe) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes decode from registers only, so they move solely at clock edges or reset.
    assign mem_if.ce_n = !((state_q == SETUP) || (state_q == STROBE));
    assign mem_if.oe_n = !(((state_q == SETUP) || (state_q == STROBE)) && !dir_q);
    assign mem_if.we_n = !((state_q == STROBE) && dir_q);

    assign mem_if.mem_busy     = !idle;
    assign mem_if.mem_ready    = (state_q == DONE);
    assign mem_if.mar          = mar;
    assign mem_if.mdr          = mdr;
    assign mem_if.data_to_sram = mdr;
    assign mem_if.addr         = {{(AddrW - WORD_W){1'b0}}, mar};

endmodule

// File: tb/tb_mem_mar_mdr_unit.sv
// Directed bench for mem_mar_mdr_unit at WaitCycles = 2, 1 and 15.
module tb_mem_mar_mdr_unit;

    logic clk;
    logic rst_ni;
    int   vectors;
    int   miscompares;

    mem_mar_mdr_unit_if #(.AddrW(20)) if_a ();
    mem_mar_mdr_unit_if #(.AddrW(20)) if_b ();
    mem_mar_mdr_unit_if #(.AddrW(20)) if_c ();

    mem_mar_mdr_unit #(.WaitCycles(2), .AddrW(20)) u_dut_a (
        .clk_i (clk), .rst_ni (rst_ni), .mem_if (if_a.slave));
    mem_mar_mdr_unit #(.WaitCycles(1), .AddrW(20)) u_dut_b (
        .clk_i (clk), .rst_ni (rst_ni), .mem_if (if_b.slave));
    mem_mar_mdr_unit #(.WaitCycles(15), .AddrW(20)) u_dut_c (
        .clk_i (clk), .rst_ni (rst_ni), .mem_if (if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are observed there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        if_a.bus_in = '0; if_a.ld_mar = 0; if_a.ld_mdr = 0; if_a.mio_en = 0;
        if_a.mem_req = 0; if_a.mem_we = 0; if_a.data_from_sram = '0;
        if_b.bus_in = '0; if_b.ld_mar = 0; if_b.ld_mdr = 0; if_b.mio_en = 0;
        if_b.mem_req = 0; if_b.mem_we = 0; if_b.data_from_sram = '0;
        if_c.bus_in = '0; if_c.ld_mar = 0; if_c.ld_mdr = 0; if_c.mio_en = 0;
        if_c.mem_req = 0; if_c.mem_we = 0; if_c.data_from_sram = '0;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({if_a.ce_n, if_a.oe_n, if_a.we_n} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 111", {if_a.ce_n, if_a.oe_n, if_a.we_n});
        end
        vectors++;
        if ({if_a.mem_busy, if_a.mem_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_busy_ready: got %b want 00", {if_a.mem_busy, if_a.mem_ready});
        end
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        vectors++;
        if (if_a.mar !== 16'h0000 || if_a.mdr !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_regs: got mar=%h mdr=%h want 0000/0000", if_a.mar, if_a.mdr);
        end
    endtask

    task automatic test_read();
        logic exp_oe;
        if_a.bus_in = 16'h3000; if_a.ld_mar = 1;
        tick();
        if_a.ld_mar = 0;
        vectors++;
        if (if_a.mar !== 16'h3000 || if_a.addr !== 20'h03000) begin
            miscompares++;
            $display("FAIL read_mar_addr: got mar=%h addr=%h want 3000/03000", if_a.mar, if_a.addr);
        end
        if_a.mem_req = 1; if_a.mem_we = 0; if_a.data_from_sram = 16'hBEEF;
        tick();
        if_a.mem_req = 0;
        for (int c = 1; c <= 4; c++) begin
            exp_oe = (c <= 3) ? 1'b0 : 1'b1;
            vectors++;
            if (if_a.oe_n !== exp_oe || if_a.mem_ready !== (c == 4)) begin
                miscompares++;
                $display("FAIL read_cycle%0d: got oe_n=%b ready=%b want %b/%b",
                         c, if_a.oe_n, if_a.mem_ready, exp_oe, (c == 4));
            end
            vectors++;
            if (if_a.mdr !== ((c == 4) ? 16'hBEEF : 16'h0000)) begin
                miscompares++;
                $display("FAIL read_mdr_cycle%0d: got %h want %h",
                         c, if_a.mdr, (c == 4) ? 16'hBEEF : 16'h0000);
            end
            tick();
        end
        vectors++;
        if (if_a.mem_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL read_idle_after: got busy=%b want 0", if_a.mem_busy);
        end
    endtask

    task automatic test_reset_mid_access();
        if_a.mem_req = 1; if_a.mem_we = 0;
        tick();
        if_a.mem_req = 0;
        tick();
        vectors++;
        if (if_a.oe_n !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_in_strobe: got oe_n=%b want 0", if_a.oe_n);
        end
        #1 rst_ni = 1'b0;
        #1;
        vectors++;
        if (if_a.ce_n !== 1'b1 || if_a.oe_n !== 1'b1 || if_a.mem_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_immediate: got ce_n=%b oe_n=%b busy=%b want 1/1/0",
                     if_a.ce_n, if_a.oe_n, if_a.mem_busy);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        vectors++;
        if (if_a.mar !== 16'h0000 || if_a.mdr !== 16'h0000 || if_a.mem_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_after: got mar=%h mdr=%h busy=%b want 0000/0000/0",
                     if_a.mar, if_a.mdr, if_a.mem_busy);
        end
    endtask

    task automatic test_write_same_edge();
        logic exp_we, exp_ce;
        if_a.ld_mdr = 1; if_a.mio_en = 0; if_a.bus_in = 16'h1234;
        if_a.mem_req = 1; if_a.mem_we = 1;
        tick();
        if_a.ld_mdr = 0; if_a.mem_req = 0; if_a.mem_we = 0; if_a.bus_in = 16'hABCD;
        for (int c = 1; c <= 4; c++) begin
            exp_we = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            exp_ce = (c <= 3) ? 1'b0 : 1'b1;
            vectors++;
            if (if_a.we_n !== exp_we || if_a.ce_n !== exp_ce || if_a.oe_n !== 1'b1) begin
                miscompares++;
                $display("FAIL write_cycle%0d: got we_n=%b ce_n=%b oe_n=%b want %b/%b/1",
                         c, if_a.we_n, if_a.ce_n, if_a.oe_n, exp_we, exp_ce);
            end
            vectors++;
            if (if_a.data_to_sram !== 16'h1234) begin
                miscompares++;
                $display("FAIL write_data_cycle%0d: got %h want 1234", c, if_a.data_to_sram);
            end
            tick();
        end
    endtask

    task automatic test_busy_ignore();
        int ready_cnt, busy_cnt;
        if_a.bus_in = 16'h0042; if_a.ld_mar = 1;
        tick();
        if_a.ld_mar = 0;
        if_a.data_from_sram = 16'hA5A5; if_a.mem_req = 1; if_a.mem_we = 0;
        tick();
        if_a.mem_req = 0;
        tick();
        busy_cnt = 2;
        ready_cnt = 0;
        if_a.ld_mar = 1; if_a.ld_mdr = 1; if_a.mio_en = 0; if_a.bus_in = 16'hFFFF;
        if_a.mem_req = 1;
        tick();
        if_a.ld_mar = 0; if_a.ld_mdr = 0; if_a.mem_req = 0;
        for (int c = 3; c <= 12; c++) begin
            if (if_a.mem_busy === 1'b1) busy_cnt++;
            if (if_a.mem_ready === 1'b1) ready_cnt++;
            tick();
        end
        vectors++;
        if (ready_cnt != 1 || busy_cnt != 4) begin
            miscompares++;
            $display("FAIL busy_ignore_counts: got ready=%0d busy=%0d want 1/4", ready_cnt, busy_cnt);
        end
        vectors++;
        if (if_a.mar !== 16'h0042 || if_a.mdr !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL busy_ignore_regs: got mar=%h mdr=%h want 0042/a5a5", if_a.mar, if_a.mdr);
        end
    endtask

    task automatic test_mio_load();
        if_a.ld_mdr = 1; if_a.mio_en = 1; if_a.bus_in = 16'h5555;
        tick();
        vectors++;
        if (if_a.mdr !== 16'hA5A5 || if_a.mem_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mio_blocks_load: got mdr=%h busy=%b want a5a5/0", if_a.mdr, if_a.mem_busy);
        end
        if_a.mio_en = 0;
        tick();
        if_a.ld_mdr = 0;
        vectors++;
        if (if_a.mdr !== 16'h5555) begin
            miscompares++;
            $display("FAIL bus_load_mdr: got %h want 5555", if_a.mdr);
        end
    endtask

    task automatic test_wait_extremes();
        int b_low, c_low, b_oe, c_oe;
        b_low = 0; c_low = 0; b_oe = 0; c_oe = 0;
        if_b.mem_req = 1; if_b.mem_we = 1;
        if_c.mem_req = 1; if_c.mem_we = 1;
        tick();
        if_b.mem_req = 0; if_b.mem_we = 0;
        if_c.mem_req = 0; if_c.mem_we = 0;
        for (int c = 1; c <= 20; c++) begin
            if (if_b.we_n === 1'b0) b_low++;
            if (if_c.we_n === 1'b0) c_low++;
            tick();
        end
        vectors++;
        if (b_low != 1 || c_low != 15) begin
            miscompares++;
            $display("FAIL wait_we_low: got w1=%0d w15=%0d want 1/15", b_low, c_low);
        end
        if_b.data_from_sram = 16'h1111; if_b.mem_req = 1;
        if_c.data_from_sram = 16'hCCCC; if_c.mem_req = 1;
        tick();
        if_b.mem_req = 0; if_c.mem_req = 0;
        for (int c = 1; c <= 20; c++) begin
            if (if_b.oe_n === 1'b0) b_oe++;
            if (if_c.oe_n === 1'b0) c_oe++;
            tick();
        end
        vectors++;
        if (b_oe != 2 || c_oe != 16) begin
            miscompares++;
            $display("FAIL wait_oe_low: got w1=%0d w15=%0d want 2/16", b_oe, c_oe);
        end
        vectors++;
        if (if_b.mdr !== 16'h1111 || if_c.mdr !== 16'hCCCC) begin
            miscompares++;
            $display("FAIL wait_read_data: got w1=%h w15=%h want 1111/cccc", if_b.mdr, if_c.mdr);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        if_b.mem_req = 1; if_b.mem_we = 0;
        tick();
        for (int c = 1; c <= 10; c++) begin
            exp_rdy = (c == 3 || c == 7);
            vectors++;
            if (if_b.mem_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL b2b_ready_cycle%0d: got %b want %b", c, if_b.mem_ready, exp_rdy);
            end
            if_b.mem_req = (c <= 4);
            tick();
        end
        if_b.mem_req = 0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_ni = 1'b0;
        drive_idle();
        test_reset();
        test_read();
        test_reset_mid_access();
        test_write_same_edge();
        test_busy_ignore();
        test_mio_load();
        test_wait_extremes();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
